ib32bit_npc: RTL and testbench

IB32BIT_NPC -- requirements
Module: ib32bit_npc

---
 rtl/ib32bit_npc.sv | 126 ++++++++++++
 tb/tb_ib32bit_npc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ib32bit_npc.sv
// Next-PC generator for a 32-bit instruction buffer: boot, sequential fetch,
// branch/jump redirects with a one-cycle flush, halt, and a saturating redirect counter.
module ib32bit_npc #(
  parameter int unsigned AWIDTH  = 6,
  parameter int unsigned RST_VEC = 5,
  parameter int unsigned CWIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [AWIDTH-1:0] br_target,
  input  logic              jmp,
  input  logic [AWIDTH-1:0] jmp_target,
  input  logic              halt,
  output logic [AWIDTH-1:0] addr_next,
  output logic              fetch_valid,
  output logic              flush,
  output logic [CWIDTH-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [AWIDTH-1:0] BOOT_ADDR = AWIDTH'(RST_VEC);
  localparam logic [AWIDTH-1:0] ADDR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CWIDTH-1:0] CNT_ONE   = {{(CWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CWIDTH-1:0] CNT_ZERO  = {CWIDTH{1'b0}};
  localparam logic [CWIDTH-1:0] CNT_MAX   = {CWIDTH{1'b1}};

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;

  // Redirect counter sticks at all-ones instead of wrapping.
  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_ONE;
    end
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      addr_q        <= BOOT_ADDR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      cnt_q         <= CNT_ZERO;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output decode. Outputs are the result of the
  // decision taken in the current state, so they trail the state by a cycle:
  // the first RUN cycle after BOOT still shows the boot address as not valid.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    fetch_valid_d = 1'b0;
    flush_d       = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        addr_d  = BOOT_ADDR;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (jmp) begin
          state_d = S_FLUSH;
          addr_d  = jmp_target;
          flush_d = 1'b1;
          cnt_d   = sat_inc(cnt_q);
        end else if (br_taken) begin
          state_d = S_FLUSH;
          addr_d  = br_target;
          flush_d = 1'b1;
          cnt_d   = sat_inc(cnt_q);
        end else if (stall) begin
          fetch_valid_d = 1'b1;
        end else begin
          addr_d        = addr_q + ADDR_ONE;
          fetch_valid_d = 1'b1;
        end
      end
      S_FLUSH: begin
        // Redirects and stall are dropped here; only halt is honoured.
        if (halt) begin
          state_d = S_HALT;
        end else begin
          state_d       = S_RUN;
          fetch_valid_d = 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
        addr_d  = BOOT_ADDR;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign addr_next   = addr_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign redir_cnt   = cnt_q;

endmodule

// File: tb/tb_ib32bit_npc.sv
// Directed bench for ib32bit_npc: expected outputs are queued when each
// step is driven and checked one cycle later against the DUT.
module tb_ib32bit_npc;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       br_taken;
  logic [5:0] br_target;
  logic       jmp;
  logic [5:0] jmp_target;
  logic       halt;
  logic [5:0] addr_next;
  logic       fetch_valid;
  logic       flush;
  logic [7:0] redir_cnt;

  typedef struct packed {
    logic [5:0] addr;
    logic       fv;
    logic       fl;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  ib32bit_npc #(.AWIDTH(6), .RST_VEC(5), .CWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .halt       (halt),
    .addr_next  (addr_next),
    .fetch_valid(fetch_valid),
    .flush      (flush),
    .redir_cnt  (redir_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic r, input logic st,
                      input logic br, input logic [5:0] bt,
                      input logic jp, input logic [5:0] jt, input logic h,
                      input logic [5:0] e_addr, input logic e_fv,
                      input logic e_fl, input logic [7:0] e_cnt);
    exp_t e;
    rst = r; stall = st; br_taken = br; br_target = bt;
    jmp = jp; jmp_target = jt; halt = h;
    sb_q.push_back('{addr: e_addr, fv: e_fv, fl: e_fl, cnt: e_cnt});
    @(posedge clk);
    #1;
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      assert (addr_next === e.addr) else begin
        bad++;
        $error("FAIL %s addr_next got=%0d exp=%0d", tag, addr_next, e.addr);
      end
      total++;
      assert (fetch_valid === e.fv) else begin
        bad++;
        $error("FAIL %s fetch_valid got=%0b exp=%0b", tag, fetch_valid, e.fv);
      end
      total++;
      assert (flush === e.fl) else begin
        bad++;
        $error("FAIL %s flush got=%0b exp=%0b", tag, flush, e.fl);
      end
      total++;
      assert (redir_cnt === e.cnt) else begin
        bad++;
        $error("FAIL %s redir_cnt got=%0d exp=%0d", tag, redir_cnt, e.cnt);
      end
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    total = 0;
    bad   = 0;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 6'd0;
    jmp = 1'b0; jmp_target = 6'd0; halt = 1'b0;

    // Reset beats a concurrent jump; holding rst stays in BOOT.
    step("rst_prio",  1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd33, 1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("rst_hold",  1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    // Idle after reset: 5,5,6,7 with fetch_valid 0,0,1,1.
    step("boot_run",  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("seq6",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd6, 1'b1, 1'b0, 8'd0);
    step("seq7",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd7, 1'b1, 1'b0, 8'd0);
    step("seq8",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd8, 1'b1, 1'b0, 8'd0);
    step("seq9",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd9, 1'b1, 1'b0, 8'd0);
    // Branch at 9 to 20; redirects presented during FLUSH are dropped.
    step("br_take",   1'b0, 1'b0, 1'b1, 6'd20, 1'b0, 6'd0,  1'b0, 6'd20, 1'b0, 1'b1, 8'd1);
    step("br_flush",  1'b0, 1'b1, 1'b1, 6'd3,  1'b1, 6'd4,  1'b0, 6'd20, 1'b1, 1'b0, 8'd1);
    step("br_inc",    1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd21, 1'b1, 1'b0, 8'd1);
    step("stall1",    1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd21, 1'b1, 1'b0, 8'd1);
    step("stall2",    1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd21, 1'b1, 1'b0, 8'd1);
    // Jump beats branch and stall, counts once.
    step("jmp_win",   1'b0, 1'b1, 1'b1, 6'd20, 1'b1, 6'd40, 1'b0, 6'd40, 1'b0, 1'b1, 8'd2);
    step("jmp_flush", 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd40, 1'b1, 1'b0, 8'd2);
    step("jmp_inc",   1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd41, 1'b1, 1'b0, 8'd2);
    // Address wrap 62,63,0,1.
    step("to62",      1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd62, 1'b0, 6'd62, 1'b0, 1'b1, 8'd3);
    step("at62",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd62, 1'b1, 1'b0, 8'd3);
    step("wrap63",    1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd63, 1'b1, 1'b0, 8'd3);
    step("wrap0",     1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 8'd3);
    step("wrap1",     1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd1,  1'b1, 1'b0, 8'd3);
    // Halt at 12 beats a jump, then jump pulses are ignored for 10 cycles.
    step("to12",      1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 6'd0,  1'b0, 6'd12, 1'b0, 1'b1, 8'd4);
    step("at12",      1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd12, 1'b1, 1'b0, 8'd4);
    step("halt",      1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd30, 1'b1, 6'd12, 1'b0, 1'b0, 8'd4);
    for (int i = 0; i < 10; i++) begin
      step("halt_hold", 1'b0, 1'b0, 1'b1, 6'd7, logic'(i % 2 == 0), 6'd30, 1'b0,
           6'd12, 1'b0, 1'b0, 8'd4);
    end
    step("rst_halt",  1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("rh_boot",   1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("rh_run",    1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd6, 1'b1, 1'b0, 8'd0);
    // Reset in the middle of FLUSH.
    step("to30",      1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd30, 1'b0, 6'd30, 1'b0, 1'b1, 8'd1);
    step("rst_flush", 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("rf_boot",   1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("rf_run",    1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd6, 1'b1, 1'b0, 8'd0);
    // Halt during FLUSH goes to HALT.
    step("to50",      1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd50, 1'b0, 6'd50, 1'b0, 1'b1, 8'd1);
    step("halt_fl",   1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd50, 1'b0, 1'b0, 8'd1);
    step("hf_hold",   1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd9,  1'b0, 6'd50, 1'b0, 1'b0, 8'd1);
    step("rst2",      1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("r2_boot",   1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);
    step("r2_run",    1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd6, 1'b1, 1'b0, 8'd0);
    // 260 back-to-back jumps: counter saturates at 255.
    exp_cnt = 8'd0;
    for (int i = 0; i < 260; i++) begin
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      step("sat_jmp", 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd10, 1'b0, 6'd10, 1'b0, 1'b1, exp_cnt);
      step("sat_fl",  1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd10, 1'b0, 6'd10, 1'b1, 1'b0, exp_cnt);
    end
    step("sat_rst",   1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5, 1'b0, 1'b0, 8'd0);

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain left=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
